mips32_state_dump: RTL

MIPS32_STATE_DUMP -- requirements
Module: mips32_state_dump

---
 rtl/mips32_dbg_pkg.sv | 24 ++
 rtl/mips32_state_dump.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mips32_dbg_pkg.sv
// Shared debug-path definitions for the MIPS32 state-dump engine:
// word width, default dump sizes, FSM state encoding and a word-count helper.
package mips32_dbg_pkg;

  localparam int WORD_W        = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int MEM_ADDR_W    = 10;
  localparam int DEF_NUM_REGS  = 32;
  localparam int DEF_MEM_WORDS = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RREQ  = 3'd1,
    ST_RWAIT = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } dump_state_e;

  // Total words streamed per dump; the memory phase only exists when enabled.
  function automatic int dump_words(input int nregs, input int mwords, input bit mem_en);
    return mem_en ? (nregs + mwords) : nregs;
  endfunction

endpackage

// File: rtl/mips32_state_dump.sv
// Streams the register file (and, with STATE_DUMP_MEM_EN defined, the first
// MEM_WORDS data-memory words) of a halted MIPS32 core over a valid/ready port.
module mips32_state_dump
  import mips32_dbg_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic                  clk1,
  input  logic                  rst,
  input  logic                  halted_i,
  input  logic                  start_i,
  output logic [REG_ADDR_W-1:0] reg_raddr_o,
  input  logic [WORD_W-1:0]     reg_rdata_i,
  output logic [MEM_ADDR_W-1:0] mem_raddr_o,
  input  logic [WORD_W-1:0]     mem_rdata_i,
  output logic                  dump_valid_o,
  input  logic                  dump_ready_i,
  output logic [WORD_W-1:0]     dump_data_o,
  output logic                  dump_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

`ifdef STATE_DUMP_MEM_EN
  localparam bit MEM_EN = 1'b1;
`else
  localparam bit MEM_EN = 1'b0;
`endif

  localparam int TOTAL = dump_words(NUM_REGS, MEM_WORDS, MEM_EN);
  localparam int IDX_W = (TOTAL < 2) ? 1 : $clog2(TOTAL + 1);

  dump_state_e           state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [REG_ADDR_W-1:0] reg_raddr_q;
  logic [WORD_W-1:0]     data_q;
  logic                  valid_q;
  logic                  last_q;
  logic                  busy_q;
  logic                  done_q;

  logic [IDX_W-1:0]      tgt_idx_d;
  logic                  tgt_is_reg_d;
  logic                  is_last_d;
  logic [WORD_W-1:0]     rd_data_d;

  // Index of the word about to be requested: 0 from IDLE, else the successor.
  always_comb begin
    tgt_idx_d    = (state_q == ST_SEND) ? (idx_q + 1'b1) : '0;
    tgt_is_reg_d = (tgt_idx_d < IDX_W'(NUM_REGS));
    is_last_d    = (idx_q == IDX_W'(TOTAL - 1));
  end

`ifdef STATE_DUMP_MEM_EN
  logic [MEM_ADDR_W-1:0] mem_raddr_q;

  always_comb begin
    rd_data_d = (idx_q >= IDX_W'(NUM_REGS)) ? mem_rdata_i : reg_rdata_i;
  end

  assign mem_raddr_o = mem_raddr_q;
`else
  logic unused_mem_d;

  always_comb begin
    rd_data_d = reg_rdata_i;
  end

  assign unused_mem_d = ^mem_rdata_i;
  assign mem_raddr_o  = '0;
`endif

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      reg_raddr_q <= '0;
`ifdef STATE_DUMP_MEM_EN
      mem_raddr_q <= '0;
`endif
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i && halted_i) begin
            busy_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= ST_RREQ;
            if (tgt_is_reg_d) begin
              reg_raddr_q <= REG_ADDR_W'(tgt_idx_d);
            end
`ifdef STATE_DUMP_MEM_EN
            else begin
              mem_raddr_q <= MEM_ADDR_W'(tgt_idx_d - IDX_W'(NUM_REGS));
            end
`endif
          end
        end

        ST_RREQ: begin
          state_q <= ST_RWAIT;
        end

        // Read data is now valid for the address launched in RREQ.
        ST_RWAIT: begin
          data_q      <= rd_data_d;
          last_q      <= is_last_d;
          valid_q     <= 1'b1;
          reg_raddr_q <= '0;
`ifdef STATE_DUMP_MEM_EN
          mem_raddr_q <= '0;
`endif
          state_q     <= ST_SEND;
        end

        ST_SEND: begin
          if (dump_ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (is_last_d) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q   <= tgt_idx_d;
              state_q <= ST_RREQ;
              if (tgt_is_reg_d) begin
                reg_raddr_q <= REG_ADDR_W'(tgt_idx_d);
              end
`ifdef STATE_DUMP_MEM_EN
              else begin
                mem_raddr_q <= MEM_ADDR_W'(tgt_idx_d - IDX_W'(NUM_REGS));
              end
`endif
            end
          end
        end

        ST_DONE: begin
          busy_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign reg_raddr_o  = reg_raddr_q;
  assign dump_valid_o = valid_q;
  assign dump_data_o  = data_q;
  assign dump_last_o  = last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
